// File: rtl/operand_sequencer.sv
// Multi-cycle operand sequencer for one decoded PucCPU instruction: fetches two operands
// (register/immediate/memory), issues them to the ALU, then writes the result back.
module operand_sequencer #(
    parameter int unsigned VALUE_WIDTH  = 16,
    parameter int unsigned OPCODE_WIDTH = 6
) (
    input  logic                    clock,
    input  logic                    resetN,

    input  logic                    instrValid,
    output logic                    instrReady,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    input  logic [7:0]              address1In,
    input  logic [7:0]              address2In,
    input  logic [7:0]              addressOut,
    input  logic [1:0]              address1Type,
    input  logic [1:0]              address2Type,
    input  logic [1:0]              outType,
    input  logic [2:0]              registerWithAddress,

    output logic [2:0]              regRdAddr,
    input  logic [VALUE_WIDTH-1:0]  regRdData,
    output logic                    regWe,
    output logic [2:0]              regWAddr,
    output logic [VALUE_WIDTH-1:0]  regWData,

    output logic                    memReq,
    output logic                    memWe,
    output logic [7:0]              memAddr,
    output logic [VALUE_WIDTH-1:0]  memWData,
    input  logic                    memAck,
    input  logic [VALUE_WIDTH-1:0]  memRData,

    output logic                    aluValid,
    input  logic                    aluReady,
    output logic [OPCODE_WIDTH-1:0] aluOpCode,
    output logic [VALUE_WIDTH-1:0]  aluOperand1,
    output logic [VALUE_WIDTH-1:0]  aluOperand2,
    input  logic                    resultValid,
    input  logic [VALUE_WIDTH-1:0]  resultData,

    output logic                    busy
);

    typedef enum logic [3:0] {
        StIdle, StFetch1, StMem1, StFetch2, StMem2, StExec, StWaitRes, StWrite, StMemw
    } state_e;

    state_e                  state_q, state_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [7:0]              addr1_q, addr1_d, addr2_q, addr2_d, addr_out_q, addr_out_d;
    logic [1:0]              type1_q, type1_d, type2_q, type2_d, type_out_q, type_out_d;
    logic [2:0]              base_reg_q, base_reg_d;
    logic [VALUE_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d, result_q, result_d;
    logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [7:0]              mem_addr_q, mem_addr_d;
    logic [VALUE_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

    // Only the low byte of the base register takes part in address arithmetic.
    logic unused_rd_hi;
    assign unused_rd_hi = ^regRdData[VALUE_WIDTH-1:8];

    always_comb begin
        regRdAddr = 3'd0;
        case (state_q)
            StFetch1:  regRdAddr = (type1_q == 2'b11) ? base_reg_q : addr1_q[2:0];
            StFetch2:  regRdAddr = (type2_q == 2'b11) ? base_reg_q : addr2_q[2:0];
            StWaitRes: regRdAddr = base_reg_q;
            default:   regRdAddr = 3'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        addr_out_d  = addr_out_q;
        type1_d     = type1_q;
        type2_d     = type2_q;
        type_out_d  = type_out_q;
        base_reg_d  = base_reg_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        result_d    = result_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            StIdle: begin
                if (instrValid) begin
                    opcode_d   = opCode;
                    addr1_d    = address1In;
                    addr2_d    = address2In;
                    addr_out_d = addressOut;
                    type1_d    = address1Type;
                    type2_d    = address2Type;
                    type_out_d = outType;
                    base_reg_d = registerWithAddress;
                    state_d    = StFetch1;
                end
            end
            StFetch1: begin
                case (type1_q)
                    2'b00: begin op1_d = regRdData; state_d = StFetch2; end
                    2'b01: begin op1_d = VALUE_WIDTH'(addr1_q); state_d = StFetch2; end
                    2'b10: begin mem_addr_d = addr1_q; mem_req_d = 1'b1; state_d = StMem1; end
                    default: begin
                        mem_addr_d = regRdData[7:0] + addr1_q;
                        mem_req_d  = 1'b1;
                        state_d    = StMem1;
                    end
                endcase
            end
            StMem1: begin
                if (memAck) begin
                    op1_d     = memRData;
                    mem_req_d = 1'b0;
                    state_d   = StFetch2;
                end
            end
            StFetch2: begin
                case (type2_q)
                    2'b00: begin op2_d = regRdData; state_d = StExec; end
                    2'b01: begin op2_d = VALUE_WIDTH'(addr2_q); state_d = StExec; end
                    2'b10: begin mem_addr_d = addr2_q; mem_req_d = 1'b1; state_d = StMem2; end
                    default: begin
                        mem_addr_d = regRdData[7:0] + addr2_q;
                        mem_req_d  = 1'b1;
                        state_d    = StMem2;
                    end
                endcase
            end
            StMem2: begin
                if (memAck) begin
                    op2_d     = memRData;
                    mem_req_d = 1'b0;
                    state_d   = StExec;
                end
            end
            StExec: begin
                if (aluReady) state_d = StWaitRes;
            end
            StWaitRes: begin
                if (resultValid) begin
                    result_d = resultData;
                    case (type_out_q)
                        2'b00: state_d = StWrite;
                        2'b01: state_d = StIdle;
                        default: begin
                            mem_addr_d  = (type_out_q == 2'b11) ? regRdData[7:0] + addr_out_q
                                                                : addr_out_q;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = resultData;
                            state_d     = StMemw;
                        end
                    endcase
                end
            end
            StWrite: state_d = StIdle;
            StMemw: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            opcode_q    <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            addr_out_q  <= '0;
            type1_q     <= '0;
            type2_q     <= '0;
            type_out_q  <= '0;
            base_reg_q  <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            addr_out_q  <= addr_out_d;
            type1_q     <= type1_d;
            type2_q     <= type2_d;
            type_out_q  <= type_out_d;
            base_reg_q  <= base_reg_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            result_q    <= result_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign instrReady  = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign aluValid    = (state_q == StExec);
    assign aluOpCode   = opcode_q;
    assign aluOperand1 = op1_q;
    assign aluOperand2 = op2_q;
    assign regWe       = (state_q == StWrite);
    assign regWAddr    = addr_out_q[2:0];
    assign regWData    = result_q;
    assign memReq      = mem_req_q;
    assign memWe       = mem_we_q;
    assign memAddr     = mem_addr_q;
    assign memWData    = mem_wdata_q;

endmodule
